// File: rtl/sram_arb_pkg.sv
// Shared definitions for the single-port SRAM arbiter: FSM encoding and
// the requester-index width helper.
package sram_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/sram_arb_rr_pick.sv
// Rotating-priority picker: first valid requester at or after ptr_i wins,
// result is a one-hot (or zero) grant vector.
module sram_arb_rr_pick
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IW'((32'(ptr_i) + i) % NUM_REQ);
      if (!found && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates NUM_REQ requesters onto one single-port SRAM with lockable
// read-modify-write ownership. Define SRAM_ARB_FIXED_PRIO_EN for fixed priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ-1:0]             i_req_write,
  input  logic [NUM_REQ-1:0]             i_req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_wdata,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [NUM_REQ-1:0]             o_rsp_valid,
  output logic [DATA_WIDTH-1:0]          o_rsp_data,
  output logic [ADDR_WIDTH-1:0]          o_mem_addr,
  output logic                           o_mem_write,
  output logic [DATA_WIDTH-1:0]          o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]          i_mem_rdata
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        lock_owner_q, lock_owner_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [NUM_REQ-1:0]   owner_mask;
  logic [NUM_REQ-1:0]   grant;
  logic [IW-1:0]        pick_ptr;
  logic [IW-1:0]        gnt_idx;
  logic                 xfer;

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = i_req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = i_req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  assign pick_ptr = rr_ptr_q;
`endif

  sram_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid_i (i_req_valid),
    .ptr_i   (pick_ptr),
    .grant_o (pick_grant)
  );

  // Grant selection; reset blanks every combinational memory-side output.
  always_comb begin
    owner_mask               = '0;
    owner_mask[lock_owner_q] = 1'b1;
    grant   = (state_q == ST_LOCKED) ? (i_req_valid & owner_mask) : pick_grant;
    if (!i_rst_n) grant = '0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[IW'(k)]) gnt_idx = IW'(k);
    end
  end

  assign xfer        = |grant;
  assign o_req_ready = grant;
  assign o_mem_write = xfer & i_req_write[gnt_idx];
  assign o_mem_addr  = xfer ? addr_a[gnt_idx]  : '0;
  assign o_mem_wdata = xfer ? wdata_a[gnt_idx] : '0;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = (|rsp_valid_q) ? i_mem_rdata : '0;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_owner_d = lock_owner_q;
    rsp_valid_d  = grant & ~i_req_write;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
          rr_ptr_d = '0;
`else
          rr_ptr_d = IW'((32'(gnt_idx) + 32'd1) % NUM_REQ);
`endif
          if (i_req_lock[gnt_idx]) begin
            state_d      = ST_LOCKED;
            lock_owner_d = gnt_idx;
          end
        end
      end
      ST_LOCKED: begin
        // Ownership persists until the owner completes an unlocked access.
        if (xfer && !i_req_lock[lock_owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      lock_owner_q <= '0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_owner_q <= lock_owner_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter (default round-robin build) with a
// one-cycle-latency SRAM model and a per-cycle response scoreboard.
module tb_sram_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;
  localparam int unsigned NR = 2;

  typedef struct packed {
    logic [1:0] v;
    logic [7:0] d;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_write, req_lock;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wd0, wd1;
  logic [1:0]    req_ready, rsp_valid;
  logic [DW-1:0] rsp_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic          mem_init;

  logic [DW-1:0] sram   [64];
  logic [DW-1:0] shadow [64];
  rsp_t          sb_q   [$];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  sram_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_write (req_write),
    .i_req_lock  (req_lock),
    .i_req_addr  ({addr1, addr0}),
    .i_req_wdata ({wd1, wd0}),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_mem_addr  (mem_addr),
    .o_mem_write (mem_write),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  // Synchronous single-port SRAM, one cycle read latency.
  always_ff @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) sram[i] <= 8'(i * 3 + 1);
    end else if (mem_write) begin
      sram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= sram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [1:0] l,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req_valid = v;
    req_write = w;
    req_lock  = l;
    addr0     = a0;
    addr1     = a1;
    wd0       = d0;
    wd1       = d1;
  endtask

  // One clock: check grant and memory drive, push expected response, pop after the edge.
  task automatic cyc(input logic [1:0] exp_gnt);
    rsp_t          e;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    #1;
    chk("ready", 32'(req_ready), 32'(exp_gnt));
    e = '0;
    if (exp_gnt != 2'b00) begin
      ea = exp_gnt[1] ? addr1 : addr0;
      ed = exp_gnt[1] ? wd1 : wd0;
      ew = exp_gnt[1] ? req_write[1] : req_write[0];
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      chk("mem_wdata", 32'(mem_wdata), 32'(ed));
      chk("mem_write", 32'(mem_write), 32'(ew));
      if (ew) begin
        shadow[ea] = ed;
      end else begin
        e.v = exp_gnt;
        e.d = shadow[ea];
      end
    end else begin
      chk("idle_mem_write", 32'(mem_write), 32'd0);
      chk("idle_mem_addr", 32'(mem_addr), 32'd0);
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("rsp_valid", 32'(rsp_valid), 32'(e.v));
    chk("rsp_data", 32'(rsp_data), 32'(e.d));
  endtask

  // Read by req0, then reset while its response is on the bus.
  task automatic reset_after_read(input logic lk);
    drive(2'b01, 2'b00, {1'b0, lk}, 6'd9, 6'd0, 8'h00, 8'h00);
    #1;
    chk("rst_pre_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("rst_pre_rsp", 32'(rsp_valid), 32'h1);
    drive(2'b11, 2'b11, 2'b00, 6'd1, 6'd2, 8'h11, 8'h22);
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_rsp", 32'(rsp_valid), 32'h0);
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    mem_init = 1'b1;
    for (int i = 0; i < 64; i++) shadow[i] = 8'(i * 3 + 1);
    drive(2'b11, 2'b11, 2'b00, 6'd7, 6'd8, 8'h55, 8'h66);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data", 32'(rsp_data), 32'h0);
    chk("reset_mem_write", 32'(mem_write), 32'h0);
    chk("reset_mem_addr", 32'(mem_addr), 32'h0);
    chk("reset_mem_wdata", 32'(mem_wdata), 32'h0);
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00);
    mem_init = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    // No requests: nothing granted, nothing returned.
    repeat (3) cyc(2'b00);

    // Two simultaneous reads from pointer 0.
    drive(2'b11, 2'b00, 2'b00, 6'd10, 6'd20, 8'h00, 8'h00);
    cyc(2'b01);
    cyc(2'b10);
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00);
    cyc(2'b00);

    // Eight cycles of contention alternate strictly.
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 2'b00, 2'b00, 6'(i), 6'(i + 32), 8'h00, 8'h00);
      cyc((i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Write then immediate read of the same address.
    drive(2'b01, 2'b01, 2'b00, 6'd5, 6'd0, 8'hA5, 8'h00);
    cyc(2'b01);
    drive(2'b01, 2'b00, 2'b00, 6'd5, 6'd0, 8'h00, 8'h00);
    cyc(2'b01);
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00);
    cyc(2'b00);

    // Locked read-modify-write by req1 while req0 keeps asking.
    drive(2'b11, 2'b00, 2'b10, 6'd7, 6'd3, 8'h00, 8'h00);
    cyc(2'b10);
    drive(2'b01, 2'b00, 2'b00, 6'd7, 6'd3, 8'h00, 8'h00);
    cyc(2'b00);
    cyc(2'b00);
    drive(2'b11, 2'b00, 2'b10, 6'd7, 6'd4, 8'h00, 8'h00);
    cyc(2'b10);
    drive(2'b11, 2'b10, 2'b00, 6'd7, 6'd3, 8'h00, 8'h3C);
    cyc(2'b10);
    drive(2'b01, 2'b00, 2'b00, 6'd7, 6'd0, 8'h00, 8'h00);
    cyc(2'b01);
    drive(2'b10, 2'b00, 2'b00, 6'd0, 6'd3, 8'h00, 8'h00);
    cyc(2'b10);
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00);
    cyc(2'b00);

    // Reset while locked: req1 must be served immediately afterwards.
    reset_after_read(1'b1);
    drive(2'b10, 2'b00, 2'b00, 6'd0, 6'd2, 8'h00, 8'h00);
    cyc(2'b10);
    drive(2'b11, 2'b00, 2'b00, 6'd11, 6'd12, 8'h00, 8'h00);
    cyc(2'b01);
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00);
    cyc(2'b00);

    // Reset after a plain req0 read: pointer restarts at req0.
    reset_after_read(1'b0);
    drive(2'b11, 2'b00, 2'b00, 6'd13, 6'd14, 8'h00, 8'h00);
    cyc(2'b01);
    cyc(2'b10);
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00);
    cyc(2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
